rob: RTL and testbench

ROB -- requirements
Module: rob

---
 rtl/rob_pkg.sv | 20 ++
 rtl/rob.sv | 107 ++++++++++
 tb/tb_rob.sv | 248 ++++++++++++++++++++++++
 3 files changed

// File: rtl/rob_pkg.sv
// Shared constants for the reorder buffer slice.
//   ROB_SEL : width of a reorder-buffer entry index
//   ROB_NUM : number of reorder-buffer entries
//   RRF_SEL : width of a rename tag (the tag is the entry index)
//   REG_SEL : width of an architectural register index
// Also provides the head-pointer advance helper used by the top.
package rob_pkg;

    localparam int ROB_SEL = 6;
    localparam int ROB_NUM = 64;
    localparam int RRF_SEL = 6;
    localparam int REG_SEL = 5;

    // Next head position; the index width equals log2(ROB_NUM), so the
    // natural modulo wrap takes ROB_NUM-1 back to entry 0.
    function automatic logic [ROB_SEL-1:0] ptr_next(input logic [ROB_SEL-1:0] ptr);
        return ptr + {{(ROB_SEL-1){1'b0}}, 1'b1};
    endfunction

endpackage

// File: rtl/rob.sv
// Reorder buffer: tracks dispatched instructions by entry index, marks them
// finished when ALU1 reports completion, and retires the oldest entry in
// program order (at most one per cycle), driving the architectural register
// file write port for it.
//
// Ports
//   clk                 : clock, all state updates on the rising edge
//   reset               : asynchronous active-high reset, clears all entries
//   dp1_i               : dispatch slot 1 valid
//   dp1_addr_i          : entry allocated by the dispatched instruction
//   dst_dp1_i           : architectural destination of the dispatched instruction
//   isValid_dst_dp1_i   : dispatched instruction writes a destination register
//   finish_ex_alu1_i    : ALU1 completion valid
//   ex_alu1_addr_i      : entry (rename tag) completed by ALU1
//   commit_ptr_1_o      : current head (oldest) entry index
//   arfwe_1_o           : architectural register write enable for the head
//   dst_arf_1_o         : architectural destination of the committing entry
module rob
    import rob_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               dp1_i,
    input  logic [ROB_SEL-1:0] dp1_addr_i,
    input  logic [REG_SEL-1:0] dst_dp1_i,
    input  logic               isValid_dst_dp1_i,
    input  logic               finish_ex_alu1_i,
    input  logic [RRF_SEL-1:0] ex_alu1_addr_i,
    output logic [ROB_SEL-1:0] commit_ptr_1_o,
    output logic               arfwe_1_o,
    output logic [REG_SEL-1:0] dst_arf_1_o
);

    // Per-entry state.
    logic [ROB_NUM-1:0] busy;
    logic [ROB_NUM-1:0] finish;
    logic [ROB_NUM-1:0] dst_valid;
    logic [REG_SEL-1:0] dst [ROB_NUM];

    // Head (oldest entry) pointer.
    logic [ROB_SEL-1:0] head;

    // Combinational commit decision for the head entry.
    logic               commit;
    // Completion and dispatch hit the same entry in this cycle.
    logic               dp_ex_same;

    // Commit decision and register-file write port for the head entry.
    always_comb begin
        commit      = busy[head] & finish[head];
        arfwe_1_o   = 1'b0;
        dst_arf_1_o = {REG_SEL{1'b0}};
        if (commit) begin
            arfwe_1_o   = dst_valid[head];
            dst_arf_1_o = dst[head];
        end else begin
            arfwe_1_o   = 1'b0;
            dst_arf_1_o = {REG_SEL{1'b0}};
        end
    end

    // A completion tag matching the entry being dispatched in the same cycle.
    always_comb begin
        dp_ex_same = 1'b0;
        if (finish_ex_alu1_i && (ex_alu1_addr_i == dp1_addr_i)) begin
            dp_ex_same = 1'b1;
        end else begin
            dp_ex_same = 1'b0;
        end
    end

    assign commit_ptr_1_o = head;

    // Entry state and head pointer update. Later assignments to the same
    // entry override earlier ones, giving the priority:
    //   completion < commit clear < dispatch.
    // The completion busy check uses the pre-edge busy bit, so a completion
    // to a non-busy entry is dropped even if that entry is dispatched now;
    // the same-cycle dispatch+completion case is handled by dp_ex_same.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            head      <= {ROB_SEL{1'b0}};
            busy      <= {ROB_NUM{1'b0}};
            finish    <= {ROB_NUM{1'b0}};
            dst_valid <= {ROB_NUM{1'b0}};
            for (int i = 0; i < ROB_NUM; i++) begin
                dst[i] <= {REG_SEL{1'b0}};
            end
        end else begin
            if (finish_ex_alu1_i && busy[ex_alu1_addr_i]) begin
                finish[ex_alu1_addr_i] <= 1'b1;
            end
            if (commit) begin
                busy[head]   <= 1'b0;
                finish[head] <= 1'b0;
                head         <= ptr_next(head);
            end
            if (dp1_i) begin
                busy[dp1_addr_i]      <= 1'b1;
                finish[dp1_addr_i]    <= dp_ex_same;
                dst[dp1_addr_i]       <= dst_dp1_i;
                dst_valid[dp1_addr_i] <= isValid_dst_dp1_i;
            end
        end
    end

endmodule

// File: tb/tb_rob.sv
// Self-checking bench for rob: directed scenarios plus randomized traffic,
// all outputs compared against a behavioural reorder-buffer model.
module tb_rob;

    logic       clk;
    logic       reset;
    logic       dp1_i;
    logic [5:0] dp1_addr_i;
    logic [4:0] dst_dp1_i;
    logic       isValid_dst_dp1_i;
    logic       finish_ex_alu1_i;
    logic [5:0] ex_alu1_addr_i;
    logic [5:0] commit_ptr_1_o;
    logic       arfwe_1_o;
    logic [4:0] dst_arf_1_o;

    int checks = 0;
    int errors = 0;

    // Reference model: entry table and head index.
    bit [63:0] m_busy;
    bit [63:0] m_fin;
    bit [63:0] m_dv;
    int        m_dst [64];
    int        m_head;
    int        tail;

    rob dut (
        .clk               (clk),
        .reset             (reset),
        .dp1_i             (dp1_i),
        .dp1_addr_i        (dp1_addr_i),
        .dst_dp1_i         (dst_dp1_i),
        .isValid_dst_dp1_i (isValid_dst_dp1_i),
        .finish_ex_alu1_i  (finish_ex_alu1_i),
        .ex_alu1_addr_i    (ex_alu1_addr_i),
        .commit_ptr_1_o    (commit_ptr_1_o),
        .arfwe_1_o         (arfwe_1_o),
        .dst_arf_1_o       (dst_arf_1_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        if (obs != exp) begin
            errors++;
            $display("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        m_busy = '0;
        m_fin  = '0;
        m_dv   = '0;
        for (int i = 0; i < 64; i++) m_dst[i] = 0;
        m_head = 0;
        tail   = 0;
    endtask

    // Compare outputs against the model's view of the head entry.
    task automatic check_outputs(input string tag);
        bit ready;
        ready = m_busy[m_head] && m_fin[m_head];
        chk({tag, ".ptr"},   int'(commit_ptr_1_o), m_head);
        chk({tag, ".arfwe"}, int'(arfwe_1_o), (ready && m_dv[m_head]) ? 1 : 0);
        chk({tag, ".dst"},   int'(dst_arf_1_o), ready ? m_dst[m_head] : 0);
    endtask

    // One clock cycle: apply inputs at the falling edge, check, advance model.
    task automatic step(input bit dp, input int a, input int d, input bit v,
                        input bit f, input int fa, input string tag);
        bit [63:0] busy_before;
        bit        retire;
        dp1_i             = dp;
        dp1_addr_i        = a[5:0];
        dst_dp1_i         = d[4:0];
        isValid_dst_dp1_i = v;
        finish_ex_alu1_i  = f;
        ex_alu1_addr_i    = fa[5:0];
        #1;
        check_outputs(tag);
        @(posedge clk);
        // Retire the oldest instruction if it has completed.
        busy_before = m_busy;
        retire      = m_busy[m_head] && m_fin[m_head];
        if (f && busy_before[fa]) m_fin[fa] = 1'b1;
        if (retire) begin
            m_busy[m_head] = 1'b0;
            m_fin[m_head]  = 1'b0;
            m_head         = (m_head + 1) % 64;
        end
        // Fresh allocation: finished only if its completion arrives together.
        if (dp) begin
            m_busy[a] = 1'b1;
            m_fin[a]  = f && (fa == a);
            m_dst[a]  = d;
            m_dv[a]   = v;
        end
        @(negedge clk);
    endtask

    task automatic idle(input string tag);
        step(1'b0, 0, 0, 1'b0, 1'b0, 0, tag);
    endtask

    // Reset held for two cycles with live-looking inputs that must be ignored.
    task automatic do_reset(input string tag);
        reset             = 1'b1;
        dp1_i             = 1'b1;
        dp1_addr_i        = 6'd0;
        dst_dp1_i         = 5'd9;
        isValid_dst_dp1_i = 1'b1;
        finish_ex_alu1_i  = 1'b1;
        ex_alu1_addr_i    = 6'd0;
        repeat (2) @(negedge clk);
        #1;
        chk({tag, ".rst_ptr"},   int'(commit_ptr_1_o), 0);
        chk({tag, ".rst_arfwe"}, int'(arfwe_1_o), 0);
        chk({tag, ".rst_dst"},   int'(dst_arf_1_o), 0);
        dp1_i            = 1'b0;
        finish_ex_alu1_i = 1'b0;
        reset            = 1'b0;
        model_clear();
        @(negedge clk);
    endtask

    initial begin
        bit dp;
        bit fn;
        int a;
        int fa;

        reset             = 1'b0;
        dp1_i             = 1'b0;
        dp1_addr_i        = 6'd0;
        dst_dp1_i         = 5'd0;
        isValid_dst_dp1_i = 1'b0;
        finish_ex_alu1_i  = 1'b0;
        ex_alu1_addr_i    = 6'd0;
        model_clear();
        @(negedge clk);

        // Reset state.
        do_reset("reset");

        // In-order commit.
        step(1'b1, 0, 5, 1'b1, 1'b0, 0, "inord");
        step(1'b1, 1, 6, 1'b1, 1'b0, 0, "inord");
        step(1'b0, 0, 0, 1'b0, 1'b1, 0, "inord");
        chk("inord.c0_we",  int'(arfwe_1_o), 1);
        chk("inord.c0_dst", int'(dst_arf_1_o), 5);
        chk("inord.c0_ptr", int'(commit_ptr_1_o), 0);
        step(1'b0, 0, 0, 1'b0, 1'b1, 1, "inord");
        chk("inord.ptr1", int'(commit_ptr_1_o), 1);
        chk("inord.c1_dst", int'(dst_arf_1_o), 6);
        idle("inord");
        chk("inord.ptr2", int'(commit_ptr_1_o), 2);
        chk("inord.we_off", int'(arfwe_1_o), 0);

        // Out-of-order completion.
        do_reset("ooo");
        step(1'b1, 0, 11, 1'b1, 1'b0, 0, "ooo");
        step(1'b1, 1, 12, 1'b1, 1'b0, 0, "ooo");
        step(1'b0, 0, 0, 1'b0, 1'b1, 1, "ooo");
        chk("ooo.no_commit", int'(arfwe_1_o), 0);
        chk("ooo.hold_ptr", int'(commit_ptr_1_o), 0);
        step(1'b0, 0, 0, 1'b0, 1'b1, 0, "ooo");
        chk("ooo.c0_dst", int'(dst_arf_1_o), 11);
        idle("ooo");
        chk("ooo.c1_dst", int'(dst_arf_1_o), 12);
        chk("ooo.c1_ptr", int'(commit_ptr_1_o), 1);
        idle("ooo");
        chk("ooo.ptr2", int'(commit_ptr_1_o), 2);

        // Same-cycle dispatch and completion at head 3.
        do_reset("samecyc");
        for (int i = 0; i < 3; i++) step(1'b1, i, i + 1, 1'b1, 1'b1, i, "samecyc");
        idle("samecyc");
        chk("samecyc.head3", int'(commit_ptr_1_o), 3);
        step(1'b1, 3, 5, 1'b1, 1'b1, 3, "samecyc");
        chk("samecyc.we",  int'(arfwe_1_o), 1);
        chk("samecyc.dst", int'(dst_arf_1_o), 5);
        idle("samecyc");
        chk("samecyc.ptr4", int'(commit_ptr_1_o), 4);

        // Commit at head colliding with dispatch to the same index.
        step(1'b1, 4, 7, 1'b1, 1'b1, 4, "collide");
        step(1'b1, 4, 8, 1'b1, 1'b0, 0, "collide");
        chk("collide.ptr5", int'(commit_ptr_1_o), 5);
        chk("collide.we",   int'(arfwe_1_o), 0);

        // Wrap-around with a no-destination entry at 63.
        do_reset("wrap");
        for (int i = 0; i < 63; i++)
            step(1'b1, i, int'($urandom_range(0, 31)), 1'(i % 2), 1'b1, i, "wrap");
        idle("wrap");
        chk("wrap.head63", int'(commit_ptr_1_o), 63);
        step(1'b1, 63, 21, 1'b0, 1'b0, 0, "wrap");
        step(1'b0, 0, 0, 1'b0, 1'b1, 63, "wrap");
        chk("wrap.we_off", int'(arfwe_1_o), 0);
        idle("wrap");
        chk("wrap.ptr0", int'(commit_ptr_1_o), 0);

        // Spurious completion to a non-busy entry at head 10.
        do_reset("spur");
        for (int i = 0; i < 10; i++) step(1'b1, i, i, 1'b1, 1'b1, i, "spur");
        idle("spur");
        step(1'b0, 0, 0, 1'b0, 1'b1, 10, "spur");
        step(1'b1, 10, 7, 1'b1, 1'b0, 0, "spur");
        idle("spur");
        chk("spur.not_fin", int'(arfwe_1_o), 0);
        chk("spur.ptr10", int'(commit_ptr_1_o), 10);
        step(1'b0, 0, 0, 1'b0, 1'b1, 10, "spur");
        chk("spur.we",  int'(arfwe_1_o), 1);
        chk("spur.dst", int'(dst_arf_1_o), 7);
        idle("spur");
        chk("spur.ptr11", int'(commit_ptr_1_o), 11);

        // Randomized traffic, mostly in allocation order near the head.
        do_reset("rand");
        for (int n = 0; n < 3000; n++) begin
            dp = ($urandom_range(0, 99) < 60);
            a  = ($urandom_range(0, 9) < 8) ? tail : int'($urandom_range(0, 63));
            if (dp && a == tail) tail = (tail + 1) % 64;
            fn = 1'($urandom_range(0, 1));
            fa = (m_head + int'($urandom_range(0, 7))) % 64;
            step(dp, a, int'($urandom_range(0, 31)), 1'($urandom_range(0, 1)), fn, fa, "rand");
            // Occasional asynchronous reset in the middle of a cycle.
            if (n % 700 == 350) begin
                #2;
                reset = 1'b1;
                #1;
                chk("rand.async_ptr",   int'(commit_ptr_1_o), 0);
                chk("rand.async_arfwe", int'(arfwe_1_o), 0);
                chk("rand.async_dst",   int'(dst_arf_1_o), 0);
                @(negedge clk);
                reset = 1'b0;
                model_clear();
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
